// File: rtl/display_pkg.sv
// Shared types and constants for the display sequencer and its dwell timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package display_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SHOW = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_HUNDREDS = 2'd0;
    localparam digit_idx_t IDX_TENS     = 2'd1;
    localparam digit_idx_t IDX_ONES     = 2'd2;
    localparam digit_idx_t IDX_OFF      = 2'd3;

    // INIT issues triggers on even counts 0,2,4 and leaves on this count
    localparam logic [2:0] INIT_LAST = 3'd5;

    // Registered output bundle driven towards the display controller
    typedef struct packed {
        logic [7:0] value;
        logic       trigger;
        logic       blank;
        logic       busy;
        logic       done;
        digit_idx_t digit_idx;
    } disp_out_t;

    localparam disp_out_t DISP_OUT_RST = '{
        value:     8'd0,
        trigger:   1'b0,
        blank:     1'b1,
        busy:      1'b1,
        done:      1'b0,
        digit_idx: IDX_HUNDREDS
    };

    // The downstream selector advances mod 4 on every trigger
    function automatic digit_idx_t next_idx(input digit_idx_t idx);
        return idx + 2'd1;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Loadable down counter that parks at zero and flags it.
// Latency: load visible next cycle; zero is combinational from the count.
// Backpressure: none; load always wins over counting.
module dwell_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/display_sequencer.sv
// Walks one 7-seg digit through hundreds/tens/ones with blank gaps between.
// Latency: trigger one cycle after an accepted start; done 3*DWELL+2*GAP later.
// Backpressure: start is dropped (not queued) while busy.
module display_sequencer
    import display_pkg::*;
#(
    parameter int DWELL_CYCLES = 10_000_000,
    parameter int GAP_CYCLES   = 2_000_000,
    parameter int CNT_W        = 24
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] value_in,
    output logic [7:0] value,
    output logic       trigger,
    output logic       blank,
    output logic       busy,
    output logic       done,
    output logic [1:0] digit_idx
);

    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam bit               HAS_GAP    = (GAP_CYCLES > 0);

    state_t           state_q, state_nxt;
    logic [2:0]       init_cnt_q, init_cnt_nxt;
    disp_out_t        out_q, out_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_zero;

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            out_q      <= DISP_OUT_RST;
        end else begin
            state_q    <= state_nxt;
            init_cnt_q <= init_cnt_nxt;
            out_q      <= out_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        init_cnt_nxt  = init_cnt_q;
        out_nxt       = out_q;
        out_nxt.trigger = 1'b0;
        out_nxt.done    = 1'b0;
        tmr_load      = 1'b0;
        tmr_load_val  = DWELL_LOAD;

        case (state_q)
            // Walk the selector from its reset state 0 to OFF with spaced pulses
            ST_INIT: begin
                init_cnt_nxt = init_cnt_q + 3'd1;
                if (init_cnt_q == INIT_LAST) begin
                    out_nxt.busy  = 1'b0;
                    out_nxt.blank = 1'b0;
                    state_nxt     = ST_IDLE;
                end else if (!init_cnt_q[0]) begin
                    out_nxt.trigger   = 1'b1;
                    out_nxt.digit_idx = next_idx(out_q.digit_idx);
                end
            end

            ST_IDLE: begin
                if (start) begin
                    out_nxt.value     = value_in;
                    out_nxt.trigger   = 1'b1;
                    out_nxt.digit_idx = next_idx(out_q.digit_idx);
                    out_nxt.busy      = 1'b1;
                    out_nxt.blank     = 1'b0;
                    tmr_load          = 1'b1;
                    tmr_load_val      = DWELL_LOAD;
                    state_nxt         = ST_SHOW;
                end
            end

            ST_SHOW: begin
                if (tmr_zero) begin
                    if (out_q.digit_idx == IDX_ONES) begin
                        out_nxt.trigger   = 1'b1;
                        out_nxt.digit_idx = next_idx(out_q.digit_idx);
                        out_nxt.done      = 1'b1;
                        out_nxt.busy      = 1'b0;
                        state_nxt         = ST_IDLE;
                    end else if (HAS_GAP) begin
                        out_nxt.blank = 1'b1;
                        tmr_load      = 1'b1;
                        tmr_load_val  = GAP_LOAD;
                        state_nxt     = ST_GAP;
                    end else begin
                        out_nxt.trigger   = 1'b1;
                        out_nxt.digit_idx = next_idx(out_q.digit_idx);
                        tmr_load          = 1'b1;
                        tmr_load_val      = DWELL_LOAD;
                    end
                end
            end

            ST_GAP: begin
                if (tmr_zero) begin
                    out_nxt.trigger   = 1'b1;
                    out_nxt.digit_idx = next_idx(out_q.digit_idx);
                    out_nxt.blank     = 1'b0;
                    tmr_load          = 1'b1;
                    tmr_load_val      = DWELL_LOAD;
                    state_nxt         = ST_SHOW;
                end
            end

            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    assign value     = out_q.value;
    assign trigger   = out_q.trigger;
    assign blank     = out_q.blank;
    assign busy      = out_q.busy;
    assign done      = out_q.done;
    assign digit_idx = out_q.digit_idx;

endmodule
